// File: rtl/fetch_hazard_sequencer_if.sv
// Fetch/issue bundle between the instruction memory, the MEM-stage branch
// resolution and the decode stage.
//   pc            fetch address to instruction memory
//   fetch_instr   word returned combinationally for pc
//   branch_taken  MEM stage: issued branch is taken (always 1 for B)
//   branch_target MEM stage: target, valid with branch_taken
//   issue_instr   IF/ID instruction register
//   issue_valid   1 = issue_instr is a real fetched instruction, 0 = bubble
//   stalling      1 = pc was held by the last edge (data hazard or shadow)
// master: the sequencer. slave: memory / pipeline environment.
interface fetch_hazard_sequencer_if;
    logic [63:0] pc;
    logic [31:0] fetch_instr;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [31:0] issue_instr;
    logic        issue_valid;
    logic        stalling;

    modport master (
        output pc, issue_instr, issue_valid, stalling,
        input  fetch_instr, branch_taken, branch_target
    );

    modport slave (
        input  pc, issue_instr, issue_valid, stalling,
        output fetch_instr, branch_taken, branch_target
    );
endinterface

// File: rtl/fetch_hazard_sequencer.sv
// Fetch stage of the 5-stage ARMv8 pipeline: owns the PC and the IF/ID
// register, decodes each fetched word and inserts NOP bubbles for RAW hazards
// (no forwarding) and for the shadow of CBZ/B while the branch resolves in MEM.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fetch_hazard_sequencer_if.master (pc, fetch_instr, branch_*,
//          issue_instr, issue_valid, stalling)
module fetch_hazard_sequencer #(
    parameter int unsigned ALU_DEPTH     = 2,
    parameter int unsigned LOAD_DEPTH    = 3,
    parameter int unsigned BRANCH_SHADOW = 3,
    parameter logic [31:0] NOP_WORD      = 32'h8B1F03FF
) (
    input logic                      clk,
    input logic                      rst_n,
    fetch_hazard_sequencer_if.master bus
);

    localparam int unsigned CntW = $clog2(BRANCH_SHADOW + 1);

    typedef enum logic {StRun, StShadow} state_e;

    state_e            state_q;
    logic [63:0]       pc_q;
    logic [31:0]       issue_instr_q;
    logic              issue_valid_q;
    logic              stalling_q;
    logic [CntW-1:0]   cnt_q;
    logic              taken_q;
    logic [63:0]       target_q;

    // Scoreboard entry k describes the instruction issued k+1 edges ago.
    logic              sb_vld_q  [LOAD_DEPTH];
    logic [4:0]        sb_rd_q   [LOAD_DEPTH];
    logic              sb_load_q [LOAD_DEPTH];

    logic [31:0] fw;
    assign fw = bus.fetch_instr;

    // Opcode classes; R-type constants are the 12-bit forms of the 11-bit field.
    logic is_ldur, is_stur, is_rtype, is_itype, is_cbz, is_b;
    assign is_ldur  = (fw[31:21] == 11'h7C2);
    assign is_stur  = (fw[31:21] == 11'h7C0);
    assign is_rtype = ({fw[31:21], 1'b0} inside {12'h8B0, 12'hCB0, 12'h8A0, 12'hAA0});
    assign is_itype = (fw[31:24] == 8'hB2) || (fw[31:22] == 10'h34D);
    assign is_cbz   = (fw[31:24] == 8'hB4);
    assign is_b     = (fw[31:26] == 6'h05);

    logic       dst_vld, src_a_vld, src_b_vld, is_load, is_branch;
    logic [4:0] dst, src_a, src_b;

    always_comb begin
        dst_vld   = 1'b0;
        dst       = fw[4:0];
        src_a_vld = 1'b0;
        src_a     = fw[9:5];
        src_b_vld = 1'b0;
        src_b     = fw[20:16];
        is_load   = 1'b0;
        is_branch = 1'b0;
        if (is_ldur) begin
            dst_vld   = 1'b1;
            src_a_vld = 1'b1;
            is_load   = 1'b1;
        end else if (is_stur) begin
            src_a_vld = 1'b1;
            src_b_vld = 1'b1;
            src_b     = fw[4:0];
        end else if (is_rtype) begin
            dst_vld   = 1'b1;
            src_a_vld = 1'b1;
            src_b_vld = 1'b1;
        end else if (is_itype) begin
            dst_vld   = 1'b1;
            src_a_vld = 1'b1;
        end else if (is_cbz) begin
            src_a_vld = 1'b1;
            src_a     = fw[4:0];
            is_branch = 1'b1;
        end else if (is_b) begin
            is_branch = 1'b1;
        end
        // XZR is never a real producer or consumer.
        if (dst == 5'd31)   dst_vld   = 1'b0;
        if (src_a == 5'd31) src_a_vld = 1'b0;
        if (src_b == 5'd31) src_b_vld = 1'b0;
    end

    // A producer only blocks while it is younger than its result latency.
    logic hazard;
    always_comb begin
        hazard = 1'b0;
        for (int unsigned k = 0; k < LOAD_DEPTH; k++) begin
            if (sb_vld_q[k] && (k < (sb_load_q[k] ? LOAD_DEPTH : ALU_DEPTH))) begin
                if ((src_a_vld && (src_a == sb_rd_q[k])) ||
                    (src_b_vld && (src_b == sb_rd_q[k]))) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    logic issue_real;
    assign issue_real = (state_q == StRun) && !hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            pc_q          <= '0;
            issue_instr_q <= NOP_WORD;
            issue_valid_q <= 1'b0;
            stalling_q    <= 1'b0;
            cnt_q         <= '0;
            taken_q       <= 1'b0;
            target_q      <= '0;
            for (int unsigned k = 0; k < LOAD_DEPTH; k++) begin
                sb_vld_q[k]  <= 1'b0;
                sb_rd_q[k]   <= '0;
                sb_load_q[k] <= 1'b0;
            end
        end else begin
            sb_vld_q[0]  <= issue_real && dst_vld;
            sb_rd_q[0]   <= dst;
            sb_load_q[0] <= is_load;
            for (int unsigned k = 1; k < LOAD_DEPTH; k++) begin
                sb_vld_q[k]  <= sb_vld_q[k-1];
                sb_rd_q[k]   <= sb_rd_q[k-1];
                sb_load_q[k] <= sb_load_q[k-1];
            end

            case (state_q)
                StRun: begin
                    if (hazard) begin
                        issue_instr_q <= NOP_WORD;
                        issue_valid_q <= 1'b0;
                        stalling_q    <= 1'b1;
                    end else begin
                        issue_instr_q <= fw;
                        issue_valid_q <= 1'b1;
                        stalling_q    <= 1'b0;
                        if (is_branch) begin
                            // PC stays on the branch until it resolves.
                            state_q <= StShadow;
                            cnt_q   <= CntW'(BRANCH_SHADOW);
                            taken_q <= 1'b0;
                        end else begin
                            pc_q <= pc_q + 64'd4;
                        end
                    end
                end
                StShadow: begin
                    issue_instr_q <= NOP_WORD;
                    issue_valid_q <= 1'b0;
                    stalling_q    <= 1'b1;
                    cnt_q         <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_q <= StRun;
                        taken_q <= 1'b0;
                        if (bus.branch_taken) begin
                            pc_q <= bus.branch_target;
                        end else if (taken_q) begin
                            pc_q <= target_q;
                        end else begin
                            pc_q <= pc_q + 64'd4;
                        end
                    end else if (bus.branch_taken) begin
                        taken_q  <= 1'b1;
                        target_q <= bus.branch_target;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.issue_instr = issue_instr_q;
    assign bus.issue_valid = issue_valid_q;
    assign bus.stalling    = stalling_q;

endmodule
